// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   - Active-low segment codes in CA..CG bit order (bit 6 = CA, bit 0 = CG).
//   - Digit count of the display.
//   - State encoding of the per-slot BLANK/ON scan FSM.
package seg_pkg;

    localparam int N_DIG = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder.
//   i_nib : BCD digit 0..9; codes 10..15 decode to an all-off pattern.
//   o_seg : active-low segments, bit 6 = CA ... bit 0 = CG.
module bcd_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nib)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
//   CLK/RST        : clock, asynchronous active-high reset.
//   VAL/DP_IN/LOAD : producer side; a LOAD pulse captures VAL and DP_IN into staging.
//   LZ_EN          : leading-zero suppression enable (level).
//   ACK            : pulse on the edge the captured value becomes the displayed value.
//   FRAME          : pulse on every digit-3 -> digit-0 wrap.
//   CA..CG, DP, AN : registered, active-low board pins.
//   DBG_STATE      : current BLANK/ON state of the slot FSM.
//
// Handshake: LOAD is a one-cycle request with no ready; every LOAD is accepted.
// Loads are held in staging until the next wrap edge, where staging moves to the
// shadow register and ACK pulses once. Several loads in a frame collapse into one
// commit (last wins). A LOAD on the wrap cycle itself is committed directly.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV  = 100000,
    parameter int BLANK_CYC = 2000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] VAL,
    input  logic [3:0]  DP_IN,
    input  logic        LOAD,
    input  logic        LZ_EN,
    output logic        ACK,
    output logic        FRAME,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic [3:0]  AN,
    output scan_state_t DBG_STATE
);

    localparam int              CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST_CNT  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END = CW'(BLANK_CYC);

    scan_state_t   r_state;
    scan_state_t   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic [1:0]    r_idx;
    logic          w_last;
    logic          w_wrap;

    logic [15:0]   r_stage;
    logic [3:0]    r_dp_stage;
    logic          r_pend;
    logic [15:0]   r_shadow;
    logic [3:0]    r_dp_shadow;

    logic [3:0]    w_nib;
    logic [6:0]    w_dec;
    logic          w_sup;
    logic          w_show;

    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_ack;
    logic          r_frame;

    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_wrap    = w_last && (r_idx == 2'd3);

    // Slot counter and digit index.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Slot FSM: the state tracks which part of the slot the counter is in,
    // so it is decided from the counter value being loaded this edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_last) begin
            w_state_nxt = ST_BLANK;
        end else if (w_cnt_inc >= BLANK_END) begin
            w_state_nxt = ST_ON;
        end else begin
            w_state_nxt = ST_BLANK;
        end
    end

    // Staging / pending / shadow. The shadow only moves on the wrap edge so a
    // frame never mixes old and new digits.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stage     <= '0;
            r_dp_stage  <= '0;
            r_pend      <= 1'b0;
            r_shadow    <= '0;
            r_dp_shadow <= '0;
            r_ack       <= 1'b0;
            r_frame     <= 1'b0;
        end else begin
            r_ack   <= 1'b0;
            r_frame <= w_wrap;
            if (LOAD) begin
                r_stage    <= VAL;
                r_dp_stage <= DP_IN;
            end
            if (w_wrap && (r_pend || LOAD)) begin
                r_shadow    <= LOAD ? VAL : r_stage;
                r_dp_shadow <= LOAD ? DP_IN : r_dp_stage;
                r_pend      <= 1'b0;
                r_ack       <= 1'b1;
            end else if (LOAD) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign w_nib = r_shadow[{r_idx, 2'b00} +: 4];

    bcd_seg_decode u_dec (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

    // Digit k is suppressed when it and every digit above it are zero.
    always_comb begin
        w_sup = 1'b0;
        if (LZ_EN) begin
            case (r_idx)
                2'd3:    w_sup = (r_shadow[15:12] == 4'd0);
                2'd2:    w_sup = (r_shadow[15:8]  == 8'd0);
                2'd1:    w_sup = (r_shadow[15:4]  == 12'd0);
                default: w_sup = 1'b0;
            endcase
        end
    end

    assign w_show = (r_state == ST_ON) && !w_sup;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_an  <= 4'hF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end else if (w_show) begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_dec;
            r_dp  <= ~r_dp_shadow[r_idx];
        end else begin
            r_an  <= 4'hF;
            r_seg <= SEG_BLANK;
            r_dp  <= 1'b1;
        end
    end

    assign AN        = r_an;
    assign CA        = r_seg[6];
    assign CB        = r_seg[5];
    assign CC        = r_seg[4];
    assign CD        = r_seg[3];
    assign CE        = r_seg[2];
    assign CF        = r_seg[1];
    assign CG        = r_seg[0];
    assign DP        = r_dp;
    assign ACK       = r_ack;
    assign FRAME     = r_frame;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int TD    = 8;
    localparam int BC    = 2;
    localparam int FRAME_LEN = 4 * TD;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] VAL = '0;
    logic [3:0]  DP_IN = '0;
    logic        LOAD = 1'b0;
    logic        LZ_EN = 1'b0;
    logic        ACK, FRAME, CA, CB, CC, CD, CE, CF, CG, DP;
    logic [3:0]  AN;
    scan_state_t dbg_state;

    seg_scan_ctrl #(.TICK_DIV(TD), .BLANK_CYC(BC)) dut (
        .CLK(CLK), .RST(RST), .VAL(VAL), .DP_IN(DP_IN), .LOAD(LOAD), .LZ_EN(LZ_EN),
        .ACK(ACK), .FRAME(FRAME), .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE),
        .CF(CF), .CG(CG), .DP(DP), .AN(AN), .DBG_STATE(dbg_state)
    );

    always #5 CLK = ~CLK;

    // observed pin bundle: {AN, CA..CG, DP, ACK, FRAME}
    wire [13:0] obs = {AN, CA, CB, CC, CD, CE, CF, CG, DP, ACK, FRAME};
    wire [6:0]  seg = {CA, CB, CC, CD, CE, CF, CG};
    localparam logic [13:0] PINS_OFF = {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    // reference model: n = edges since reset release; displayed value and pending load
    int          n;
    logic [15:0] m_shadow, m_stage;
    logic [3:0]  m_dp, m_dp_stage;
    bit          m_pend;
    logic [13:0] exp_pins;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic void model_reset();
        n = 0; m_shadow = '0; m_stage = '0; m_dp = '0; m_dp_stage = '0; m_pend = 0;
        exp_pins = PINS_OFF;
    endfunction

    // Pins after an edge follow the slot position that held before it.
    function automatic void model_edge();
        int  slot = (n / TD) % 4;
        int  off  = n % TD;
        bit  wrap = (n % FRAME_LEN) == FRAME_LEN - 1;
        bit  sup  = LZ_EN && slot > 0 && ((m_shadow >> (4 * slot)) == 16'd0);
        bit  on   = (off >= BC) && !sup;
        logic [3:0] nib = 4'(m_shadow >> (4 * slot));
        logic [3:0] an  = on ? ~(4'(1 << slot)) : 4'hF;
        bit  commit = wrap && (m_pend || LOAD);
        exp_pins = {an, on ? seg_of(nib) : 7'h7F, on ? ~m_dp[slot] : 1'b1, commit, wrap};
        if (commit) begin
            m_shadow = LOAD ? VAL : m_stage;
            m_dp     = LOAD ? DP_IN : m_dp_stage;
            m_pend   = 0;
        end else if (LOAD) begin
            m_stage = VAL; m_dp_stage = DP_IN; m_pend = 1;
        end
        n++;
    endfunction

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    // advance without checking until the next edge is at frame position pos
    task automatic idle_to(input int pos);
        for (int i = 0; i < FRAME_LEN && (n % FRAME_LEN) != pos; i++) cycle();
    endtask

    function automatic int last_pos();
        return (n - 1) % FRAME_LEN;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (obs !== PINS_OFF) begin
            errors++; $display("FAIL reset_pins got %b exp %b", obs, PINS_OFF);
        end
        checks++;
        if (dbg_state !== ST_BLANK) begin
            errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_BLANK);
        end
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (AN !== 4'hF) begin
                errors++; $display("FAIL reset_blank_an cyc=%0d got %b exp 1111", i, AN);
            end
        end
        cycle();
        checks++;
        if ({AN, seg} !== {4'b1110, 7'b0000001}) begin
            errors++; $display("FAIL reset_first_digit got %b/%b exp 1110/0000001", AN, seg);
        end
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            cycle();
            checks++;
            if (obs !== exp_pins) begin
                errors++; $display("FAIL reset_scan n=%0d got %b exp %b", n, obs, exp_pins);
            end
        end
    endtask

    task automatic test_basic_load();
        int acks = 0;
        idle_to(5);
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            LOAD = (i == 0); VAL = 16'h1234; DP_IN = 4'b0000;
            cycle();
            LOAD = 1'b0;
            checks++;
            if (obs !== exp_pins) begin
                errors++; $display("FAIL basic_load n=%0d got %b exp %b", n, obs, exp_pins);
            end
            if (ACK) acks++;
            if (acks == 1 && last_pos() == 4) begin
                checks++;
                if ({AN, seg} !== {4'b1110, 7'b1001100}) begin
                    errors++; $display("FAIL basic_digit0 got %b/%b exp 1110/1001100", AN, seg);
                end
            end
            if (acks == 1 && last_pos() == 28) begin
                checks++;
                if ({AN, seg} !== {4'b0111, 7'b1001111}) begin
                    errors++; $display("FAIL basic_digit3 got %b/%b exp 0111/1001111", AN, seg);
                end
            end
        end
        checks++;
        if (acks !== 1) begin
            errors++; $display("FAIL basic_ack_count got %0d exp 1", acks);
        end
    endtask

    task automatic test_last_wins();
        int acks = 0;
        int gap = $urandom_range(1, 20);
        idle_to(3);
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            LOAD = (i == 0) || (i == gap);
            VAL  = (i == 0) ? 16'h1111 : 16'h5678;
            cycle();
            LOAD = 1'b0;
            checks++;
            if (obs !== exp_pins) begin
                errors++; $display("FAIL last_wins n=%0d got %b exp %b", n, obs, exp_pins);
            end
            if (ACK) acks++;
            if (acks == 1 && last_pos() == 28) begin
                checks++;
                if ({AN, seg} !== {4'b0111, 7'b0100100}) begin
                    errors++; $display("FAIL last_wins_digit3 got %b/%b exp 0111/0100100", AN, seg);
                end
            end
        end
        checks++;
        if (acks !== 1) begin
            errors++; $display("FAIL last_wins_ack_count got %0d exp 1", acks);
        end
    endtask

    task automatic test_lz();
        int acks = 0;
        int lit = 0;
        LZ_EN = 1'b1;
        idle_to(10);
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            LOAD = (i == 0); VAL = 16'h0040; DP_IN = 4'b1100;
            cycle();
            LOAD = 1'b0;
            checks++;
            if (obs !== exp_pins) begin
                errors++; $display("FAIL lz n=%0d got %b exp %b", n, obs, exp_pins);
            end
            if (ACK) acks++;
            if (acks == 1 && last_pos() >= 16 && last_pos() != 31 && AN !== 4'hF) lit++;
            if (acks == 1 && last_pos() == 12) begin
                checks++;
                if ({AN, seg} !== {4'b1101, 7'b1001100}) begin
                    errors++; $display("FAIL lz_digit1 got %b/%b exp 1101/1001100", AN, seg);
                end
            end
        end
        checks++;
        if (lit !== 0) begin
            errors++; $display("FAIL lz_suppressed_lit got %0d exp 0", lit);
        end
        LZ_EN = 1'b0;
    endtask

    task automatic test_boundary();
        idle_to(FRAME_LEN - 1);
        LOAD = 1'b1; VAL = 16'h000A; DP_IN = 4'b0001;
        cycle();
        LOAD = 1'b0;
        checks++;
        if ({ACK, FRAME} !== 2'b11) begin
            errors++; $display("FAIL wrap_load_ack got %b exp 11", {ACK, FRAME});
        end
        for (int i = 0; i < FRAME_LEN; i++) begin
            cycle();
            checks++;
            if (obs !== exp_pins) begin
                errors++; $display("FAIL boundary n=%0d got %b exp %b", n, obs, exp_pins);
            end
            if (last_pos() == 4) begin
                checks++;
                if ({AN, seg, DP} !== {4'b1110, 7'h7F, 1'b0}) begin
                    errors++; $display("FAIL nibble_a got %b/%b/%b exp 1110/1111111/0", AN, seg, DP);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12 * FRAME_LEN; i++) begin
            logic [15:0] v;
            for (int k = 0; k < 4; k++)
                v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            LOAD  = ($urandom_range(0, 9) == 0);
            VAL   = v;
            DP_IN = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) LZ_EN = ~LZ_EN;
            cycle();
            checks++;
            if (obs !== exp_pins) begin
                errors++; $display("FAIL random n=%0d got %b exp %b", n, obs, exp_pins);
            end
        end
        LOAD = 1'b0; LZ_EN = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        idle_to(19);
        LOAD = 1'b1; VAL = 16'h9999; DP_IN = 4'hF;
        cycle();
        LOAD = 1'b0;
        cycle();
        checks++;
        if (AN !== 4'b1011) begin
            errors++; $display("FAIL mid_on_before_rst got %b exp 1011", AN);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (obs !== PINS_OFF) begin
            errors++; $display("FAIL mid_rst_pins got %b exp %b", obs, PINS_OFF);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            cycle();
            checks++;
            if (obs !== exp_pins) begin
                errors++; $display("FAIL after_rst n=%0d got %b exp %b", n, obs, exp_pins);
            end
            if (ACK) acks++;
        end
        checks++;
        if (acks !== 0) begin
            errors++; $display("FAIL after_rst_ack_count got %0d exp 0", acks);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_load();
        test_last_wins();
        test_lz();
        test_boundary();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
